traffic_light_ctrl_n: RTL and testbench
=======================================

Name: traffic_light_ctrl_n

Overview:
Parametrised traffic-light controller for an intersection with N_WAYS approaches. Serves the approaches one at a time in round-robin order. Each green phase is followed by a yellow phase and an optional all-red clearance phase.
A night mode flashes every yellow lamp. All phase durations are parameters, counted in clk cycles. The block drives the lamp outputs directly and sits below the intersection top level.

Parameters:
N_WAYS, 2, number of approaches (2..8)
GREEN_T, 5, green phase length in cycles (>=1)
YELLOW_T, 2, yellow phase length in cycles (>=1)
ALLRED_T, 1, all-red clearance length in cycles (0 = phase skipped)
BLINK_T, 1, night-mode on/off half-period in cycles (>=1)
CNT_W, 8, phase timer width; must hold max(GREEN_T,YELLOW_T,ALLRED_T,BLINK_T)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low
night_mode  input  1  1 = flashing-yellow mode, 0 = day cycling; sampled every rising edge
demand  input  N_WAYS  per-approach vehicle-present flag; used only with SENSOR_SKIP_EN
green  output  N_WAYS  green lamp per approach
yellow  output  N_WAYS  yellow lamp per approach
red  output  N_WAYS  red lamp per approach
active_way  output  3  index of the approach currently served
phase  output  3  encoded state: 0 GREEN, 1 YELLOW, 2 ALLRED, 3 NIGHT_ON, 4 NIGHT_OFF

Behaviour:
- Reset (reset=0, asynchronous) forces state=GREEN, active_way=0, timer=0. Outputs during reset: green=1 on way 0; red=1 on all other ways; yellow=0.
- Registered FSM with Moore outputs, decoded combinationally from state and active_way.
- Lamp decode:
  - GREEN: the active way shows green only.
  - YELLOW: the active way shows yellow only.
  - In GREEN and YELLOW, every other way shows red only.
  - ALLRED: all ways show red.
  - NIGHT_ON: all ways show yellow, no other lamp.
  - NIGHT_OFF: all lamps off.
  - Exactly one lamp per way is lit, except in NIGHT_OFF.
- Timer: clears on every state change and increments once per cycle otherwise. A phase of length T exits on the edge where timer==T-1, so it occupies exactly T cycles.
- Day transitions (night_mode=0):
  - GREEN -> YELLOW after GREEN_T cycles.
  - YELLOW -> ALLRED after YELLOW_T cycles, or directly to GREEN when ALLRED_T=0.
  - ALLRED -> GREEN after ALLRED_T cycles.
  - active_way advances to (active_way+1) mod N_WAYS on entry to the next GREEN. It wraps from N_WAYS-1 to 0.
- Entering night (night_mode=1 sampled):
  - In GREEN: go to YELLOW immediately on the next edge with timer cleared. Green is never cut straight to dark.
  - YELLOW runs its full YELLOW_T, then goes to NIGHT_ON. No ALLRED phase.
  - In ALLRED: go to NIGHT_ON immediately on the next edge.
- Night blinking: NIGHT_ON and NIGHT_OFF alternate, each lasting BLINK_T cycles. active_way holds its value.
- Leaving night (night_mode=0 sampled in NIGHT_ON or NIGHT_OFF):
  - Go to ALLRED with timer cleared; when ALLRED_T=0, go to GREEN instead.
  - Next GREEN serves way 0, not the incremented way.
- night_mode toggling inside YELLOW has no effect until YELLOW ends; the value sampled on YELLOW's final edge selects the target.
- Reset asserted mid-phase takes effect immediately; no phase is completed.
- active_way is always < N_WAYS.

Optional Feature:
Macro SENSOR_SKIP_EN.
- Defined, day mode:
  - On the final GREEN edge, if no way other than active_way has demand=1, the FSM stays in GREEN and the timer restarts at 0. The green holds in GREEN_T chunks.
  - Otherwise the cycle proceeds through YELLOW/ALLRED. The next GREEN serves the first way with demand=1 in circular order after the previous active_way.
  - demand is sampled on the entry edge of that GREEN; if no way has demand=1 there, the next way in circular order is served.
  - Leaving night mode still serves way 0.
- Undefined: the demand port still exists, is ignored, and is unconnected internally; plain round-robin applies.

Test Plan:
- Reset release with N_WAYS=2, defaults, night_mode=0 -> way0 green for 5 cycles, yellow 2, all-red 1, then way1 green for 5; pattern repeats with period 16.
- N_WAYS=4, ALLRED_T=0 -> service order 0,1,2,3,0; YELLOW goes straight to GREEN; no cycle has all ways red.
- night_mode=1 raised at timer=2 of way1 GREEN -> next cycle way1 yellow for 2 cycles, then all-yellow on 1 cycle / off 1 cycle, repeating.
- night_mode=0 during NIGHT_OFF -> all-red for 1 cycle, then way0 green for 5 cycles, even though way1 was active before night.
- reset pulled low mid-YELLOW of way2 (N_WAYS=3) -> outputs immediately become green=001, red=110, yellow=000.
- SENSOR_SKIP_EN, N_WAYS=4, demand=0100 while way0 green -> way0 yellow, all-red, then way2 green; with demand=0001 the way0 green holds and timer restarts.

Source files
------------

// File: rtl/traffic_light_ctrl_n_if.sv
// Lamp/control bundle for traffic_light_ctrl_n: the intersection top level is the
// master (mode and demand requests), the controller is the slave (lamp drive).
interface traffic_light_ctrl_n_if #(
   parameter int N_WAYS = 2
);
   logic              night_mode;
   logic [N_WAYS-1:0] demand;
   logic [N_WAYS-1:0] green;
   logic [N_WAYS-1:0] yellow;
   logic [N_WAYS-1:0] red;
   logic [2:0]        active_way;
   logic [2:0]        phase;

   modport master (
      output night_mode, demand,
      input  green, yellow, red, active_way, phase
   );

   modport slave (
      input  night_mode, demand,
      output green, yellow, red, active_way, phase
   );
endinterface

// File: rtl/traffic_light_ctrl_n.sv
// Round-robin traffic-light controller with yellow, optional all-red and night blinking.
// Optional demand-driven skipping of idle approaches: define SENSOR_SKIP_EN.
module traffic_light_ctrl_n #(
   parameter int N_WAYS   = 2,
   parameter int GREEN_T  = 5,
   parameter int YELLOW_T = 2,
   parameter int ALLRED_T = 1,
   parameter int BLINK_T  = 1,
   parameter int CNT_W    = 8
) (
   input logic clk,
   input logic reset,
   traffic_light_ctrl_n_if.slave bus
);

   typedef enum logic [2:0] {
      GREEN     = 3'd0,
      YELLOW    = 3'd1,
      ALLRED    = 3'd2,
      NIGHT_ON  = 3'd3,
      NIGHT_OFF = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'((ALLRED_T > 0) ? ALLRED_T - 1 : 0);
   localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_T - 1);

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        active_way;
   logic [2:0]        way_nxt;
   logic [2:0]        day_next_way;
   logic [CNT_W-1:0]  timer;
   logic              timer_clr;
   logic              night_exit;
   logic              night_exit_nxt;
   logic [N_WAYS-1:0] way_hot;
   logic [N_WAYS-1:0] green_d;
   logic [N_WAYS-1:0] yellow_d;
   logic [N_WAYS-1:0] red_d;

   function automatic logic [2:0] next_way(input logic [2:0] w);
      return (int'(w) == N_WAYS - 1) ? 3'd0 : w + 3'd1;
   endfunction

   assign way_hot = N_WAYS'(1) << active_way;

`ifdef SENSOR_SKIP_EN
   logic [N_WAYS-1:0] other_demand;

   // First requesting way after cur in circular order; plain successor when nobody asks.
   function automatic logic [2:0] pick_way(input logic [2:0] cur, input logic [N_WAYS-1:0] dem);
      logic [2:0] sel;
      logic       found;
      int         idx;
      sel   = next_way(cur);
      found = 1'b0;
      for (int i = 1; i < N_WAYS; i++) begin
         idx = (int'(cur) + i) % N_WAYS;
         if (!found && dem[idx]) begin
            sel   = 3'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign other_demand = bus.demand & ~way_hot;
   assign day_next_way = pick_way(active_way, bus.demand);
`else
   logic unused_demand;

   assign unused_demand = ^bus.demand;
   assign day_next_way  = next_way(active_way);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= GREEN;
         active_way <= 3'd0;
         timer      <= '0;
         night_exit <= 1'b0;
      end else begin
         state      <= state_nxt;
         active_way <= way_nxt;
         timer      <= timer_clr ? '0 : timer + CNT_W'(1);
         night_exit <= night_exit_nxt;
      end
   end

   // night_exit remembers that the pending GREEN follows a night period and must restart at way 0.
   always_comb begin
      state_nxt      = state;
      way_nxt        = active_way;
      timer_clr      = 1'b0;
      night_exit_nxt = night_exit;
      case (state)
         GREEN: begin
            if (bus.night_mode) begin
               state_nxt = YELLOW;
            end else if (timer == GREEN_LAST) begin
`ifdef SENSOR_SKIP_EN
               if (other_demand == '0) begin
                  timer_clr = 1'b1;
               end else begin
                  state_nxt = YELLOW;
               end
`else
               state_nxt = YELLOW;
`endif
            end
         end
         YELLOW: begin
            if (timer == YELLOW_LAST) begin
               if (bus.night_mode) begin
                  state_nxt = NIGHT_ON;
               end else if (ALLRED_T == 0) begin
                  state_nxt = GREEN;
                  way_nxt   = day_next_way;
               end else begin
                  state_nxt = ALLRED;
               end
            end
         end
         ALLRED: begin
            if (bus.night_mode) begin
               state_nxt = NIGHT_ON;
            end else if (timer == ALLRED_LAST) begin
               state_nxt = GREEN;
               way_nxt   = night_exit ? 3'd0 : day_next_way;
            end
         end
         NIGHT_ON, NIGHT_OFF: begin
            if (!bus.night_mode) begin
               if (ALLRED_T == 0) begin
                  state_nxt = GREEN;
                  way_nxt   = 3'd0;
               end else begin
                  state_nxt      = ALLRED;
                  night_exit_nxt = 1'b1;
               end
            end else if (timer == BLINK_LAST) begin
               state_nxt = (state == NIGHT_ON) ? NIGHT_OFF : NIGHT_ON;
            end
         end
         default: begin
            state_nxt = GREEN;
            way_nxt   = 3'd0;
         end
      endcase
      if (state_nxt == GREEN && state != GREEN) begin
         night_exit_nxt = 1'b0;
      end
      if (state_nxt != state) begin
         timer_clr = 1'b1;
      end
   end

   always_comb begin
      green_d  = '0;
      yellow_d = '0;
      red_d    = '0;
      case (state)
         GREEN: begin
            green_d = way_hot;
            red_d   = ~way_hot;
         end
         YELLOW: begin
            yellow_d = way_hot;
            red_d    = ~way_hot;
         end
         ALLRED:    red_d    = '1;
         NIGHT_ON:  yellow_d = '1;
         NIGHT_OFF: red_d    = '0;
         default:   red_d    = '1;
      endcase
   end

   assign bus.green      = green_d;
   assign bus.yellow     = yellow_d;
   assign bus.red        = red_d;
   assign bus.active_way = active_way;
   assign bus.phase      = 3'(state);

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Directed self-checking bench for traffic_light_ctrl_n across several parameter sets.
// Outputs are checked on the falling edge; inputs are changed right after checking.
module tb_traffic_light_ctrl_n;

   logic clk = 1'b0;
   logic reset0, reset1, reset2, reset3;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   traffic_light_ctrl_n_if #(.N_WAYS(2)) bus0 ();
   traffic_light_ctrl_n_if #(.N_WAYS(4)) bus1 ();
   traffic_light_ctrl_n_if #(.N_WAYS(3)) bus2 ();
   traffic_light_ctrl_n_if #(.N_WAYS(4)) bus3 ();

   traffic_light_ctrl_n #(.N_WAYS(2)) u0 (.clk(clk), .reset(reset0), .bus(bus0));
   traffic_light_ctrl_n #(.N_WAYS(4), .ALLRED_T(0)) u1 (.clk(clk), .reset(reset1), .bus(bus1));
   traffic_light_ctrl_n #(.N_WAYS(3)) u2 (.clk(clk), .reset(reset2), .bus(bus2));
   traffic_light_ctrl_n #(.N_WAYS(4)) u3 (.clk(clk), .reset(reset3), .bus(bus3));

   task automatic test_reset();
      @(negedge clk);
      reset0 = 1'b0;
      #1;
      checks++;
      if ({bus0.phase, bus0.active_way, bus0.green, bus0.yellow, bus0.red} !== {3'd0, 3'd0, 2'b01, 2'b00, 2'b10}) begin
         errors++;
         $display("[TB] FAIL reset_state: got ph=%0d way=%0d g=%b y=%b r=%b, want ph=0 way=0 g=01 y=00 r=10",
                  bus0.phase, bus0.active_way, bus0.green, bus0.yellow, bus0.red);
      end
      @(negedge clk);
      checks++;
      if ({bus0.green, bus0.yellow, bus0.red} !== 6'b01_00_10) begin
         errors++;
         $display("[TB] FAIL reset_hold: got g=%b y=%b r=%b, want g=01 y=00 r=10", bus0.green, bus0.yellow, bus0.red);
      end
   endtask

   // Defaults, two ways: 5 green, 2 yellow, 1 all-red per way, period 16.
   task automatic test_day_cycle();
      int pos, sub, ew, ep;
      logic [1:0] eg, ey, er;
      reset0 = 1'b1;
      #1;
      for (int k = 0; k < 34; k++) begin
         if (k > 0) @(negedge clk);
         pos = k % 16;
         ew  = (pos < 8) ? 0 : 1;
         sub = pos % 8;
         ep  = (sub < 5) ? 0 : ((sub < 7) ? 1 : 2);
         eg  = 2'b00;
         ey  = 2'b00;
         er  = 2'b11;
         if (ep == 0) begin
            eg = (ew == 1) ? 2'b10 : 2'b01;
            er = (ew == 1) ? 2'b01 : 2'b10;
         end else if (ep == 1) begin
            ey = (ew == 1) ? 2'b10 : 2'b01;
            er = (ew == 1) ? 2'b01 : 2'b10;
         end
         checks++;
         if ({bus0.phase, bus0.active_way, bus0.green, bus0.yellow, bus0.red} !== {3'(ep), 3'(ew), eg, ey, er}) begin
            errors++;
            $display("[TB] FAIL day_cycle k=%0d: got ph=%0d way=%0d g=%b y=%b r=%b, want ph=%0d way=%0d g=%b y=%b r=%b",
                     k, bus0.phase, bus0.active_way, bus0.green, bus0.yellow, bus0.red, ep, ew, eg, ey, er);
         end
      end
   endtask

   // Four ways without all-red: 5 green then 2 yellow, order 0,1,2,3,0.
   task automatic test_allred_zero();
      int ew, ep;
      logic [3:0] eg, ey, er;
      @(negedge clk);
      reset1 = 1'b0;
      @(negedge clk);
      reset1 = 1'b1;
      #1;
      for (int k = 0; k < 31; k++) begin
         if (k > 0) @(negedge clk);
         ew = (k / 7) % 4;
         ep = ((k % 7) < 5) ? 0 : 1;
         eg = (ep == 0) ? (4'b0001 << ew) : 4'b0000;
         ey = (ep == 1) ? (4'b0001 << ew) : 4'b0000;
         er = ~(4'b0001 << ew);
         checks++;
         if ({bus1.phase, bus1.active_way, bus1.green, bus1.yellow, bus1.red} !== {3'(ep), 3'(ew), eg, ey, er}) begin
            errors++;
            $display("[TB] FAIL allred_zero k=%0d: got ph=%0d way=%0d g=%b y=%b r=%b, want ph=%0d way=%0d g=%b y=%b r=%b",
                     k, bus1.phase, bus1.active_way, bus1.green, bus1.yellow, bus1.red, ep, ew, eg, ey, er);
         end
         checks++;
         if (bus1.red === 4'b1111) begin
            errors++;
            $display("[TB] FAIL no_all_red k=%0d: got r=%b, want not 1111", k, bus1.red);
         end
      end
   endtask

   // Night requested at timer=2 of way1 green: yellow 2, then blink on/off.
   task automatic test_night_entry();
      logic [11:0] tab [6];
      tab = '{{3'd1, 3'd1, 2'b00, 2'b10, 2'b01},
              {3'd1, 3'd1, 2'b00, 2'b10, 2'b01},
              {3'd3, 3'd1, 2'b00, 2'b11, 2'b00},
              {3'd4, 3'd1, 2'b00, 2'b00, 2'b00},
              {3'd3, 3'd1, 2'b00, 2'b11, 2'b00},
              {3'd4, 3'd1, 2'b00, 2'b00, 2'b00}};
      @(negedge clk);
      reset0 = 1'b0;
      @(negedge clk);
      reset0 = 1'b1;
      for (int k = 1; k <= 10; k++) @(negedge clk);
      checks++;
      if ({bus0.phase, bus0.active_way, bus0.green} !== {3'd0, 3'd1, 2'b10}) begin
         errors++;
         $display("[TB] FAIL night_pre: got ph=%0d way=%0d g=%b, want ph=0 way=1 g=10",
                  bus0.phase, bus0.active_way, bus0.green);
      end
      bus0.night_mode = 1'b1;
      for (int k = 11; k <= 16; k++) begin
         @(negedge clk);
         checks++;
         if ({bus0.phase, bus0.active_way, bus0.green, bus0.yellow, bus0.red} !== tab[k-11]) begin
            errors++;
            $display("[TB] FAIL night_entry k=%0d: got %b, want %b (ph,way,g,y,r)",
                     k, {bus0.phase, bus0.active_way, bus0.green, bus0.yellow, bus0.red}, tab[k-11]);
         end
      end
   endtask

   // Leaving night from NIGHT_OFF: all-red 1, then way0 (not way1) green 5, yellow 2, all-red, way1.
   task automatic test_night_exit();
      logic [8:0] tab [10];
      tab = '{{3'd2, 2'b00, 2'b00, 2'b11},
              {3'd0, 2'b01, 2'b00, 2'b10},
              {3'd0, 2'b01, 2'b00, 2'b10},
              {3'd0, 2'b01, 2'b00, 2'b10},
              {3'd0, 2'b01, 2'b00, 2'b10},
              {3'd0, 2'b01, 2'b00, 2'b10},
              {3'd1, 2'b00, 2'b01, 2'b10},
              {3'd1, 2'b00, 2'b01, 2'b10},
              {3'd2, 2'b00, 2'b00, 2'b11},
              {3'd0, 2'b10, 2'b00, 2'b01}};
      bus0.night_mode = 1'b0;
      for (int k = 17; k <= 26; k++) begin
         @(negedge clk);
         checks++;
         if ({bus0.phase, bus0.green, bus0.yellow, bus0.red} !== tab[k-17]) begin
            errors++;
            $display("[TB] FAIL night_exit k=%0d: got %b, want %b (ph,g,y,r)",
                     k, {bus0.phase, bus0.green, bus0.yellow, bus0.red}, tab[k-17]);
         end
         if (k >= 18 && k <= 25) begin
            checks++;
            if (bus0.active_way !== 3'd0) begin
               errors++;
               $display("[TB] FAIL night_exit_way k=%0d: got %0d, want 0", k, bus0.active_way);
            end
         end
      end
   endtask

   // Three ways: way2 yellow at cycles 21-22; reset mid-yellow acts without a clock edge.
   task automatic test_reset_mid_yellow();
      @(negedge clk);
      reset2 = 1'b0;
      @(negedge clk);
      reset2 = 1'b1;
      for (int k = 1; k <= 21; k++) @(negedge clk);
      checks++;
      if ({bus2.phase, bus2.active_way, bus2.green, bus2.yellow, bus2.red} !== {3'd1, 3'd2, 3'b000, 3'b100, 3'b011}) begin
         errors++;
         $display("[TB] FAIL mid_yellow_pre: got ph=%0d way=%0d g=%b y=%b r=%b, want ph=1 way=2 g=000 y=100 r=011",
                  bus2.phase, bus2.active_way, bus2.green, bus2.yellow, bus2.red);
      end
      #2;
      reset2 = 1'b0;
      #1;
      checks++;
      if ({bus2.phase, bus2.active_way, bus2.green, bus2.yellow, bus2.red} !== {3'd0, 3'd0, 3'b001, 3'b000, 3'b110}) begin
         errors++;
         $display("[TB] FAIL mid_yellow_reset: got ph=%0d way=%0d g=%b y=%b r=%b, want ph=0 way=0 g=001 y=000 r=110",
                  bus2.phase, bus2.active_way, bus2.green, bus2.yellow, bus2.red);
      end
      @(negedge clk);
      reset2 = 1'b1;
      for (int k = 1; k <= 5; k++) @(negedge clk);
      checks++;
      if ({bus2.phase, bus2.active_way, bus2.yellow} !== {3'd1, 3'd0, 3'b001}) begin
         errors++;
         $display("[TB] FAIL mid_yellow_restart: got ph=%0d way=%0d y=%b, want ph=1 way=0 y=001",
                  bus2.phase, bus2.active_way, bus2.yellow);
      end
   endtask

`ifdef SENSOR_SKIP_EN
   // Only way0 requests: green holds in 5-cycle chunks; then way2 requests and is served next.
   task automatic test_demand();
      logic [13:0] exp_v;
      bus3.demand = 4'b0001;
      @(negedge clk);
      reset3 = 1'b0;
      @(negedge clk);
      reset3 = 1'b1;
      #1;
      for (int k = 0; k <= 18; k++) begin
         if (k > 0) @(negedge clk);
         if (k <= 14)      exp_v = {3'd0, 3'd0, 4'b0001, 4'b0000};
         else if (k <= 16) exp_v = {3'd1, 3'd0, 4'b0000, 4'b0001};
         else if (k == 17) exp_v = {3'd2, 3'd0, 4'b0000, 4'b0000};
         else              exp_v = {3'd0, 3'd2, 4'b0100, 4'b0000};
         checks++;
         if ({bus3.phase, bus3.active_way, bus3.green, bus3.yellow} !== exp_v) begin
            errors++;
            $display("[TB] FAIL sensor_skip k=%0d: got %b, want %b (ph,way,g,y)",
                     k, {bus3.phase, bus3.active_way, bus3.green, bus3.yellow}, exp_v);
         end
         if (k == 12) bus3.demand = 4'b0100;
      end
   endtask
`else
   // Demand is ignored: way0 green 5, yellow 2, all-red 1, then way1 despite demand=0001.
   task automatic test_demand();
      logic [13:0] exp_v;
      bus3.demand = 4'b0001;
      @(negedge clk);
      reset3 = 1'b0;
      @(negedge clk);
      reset3 = 1'b1;
      #1;
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) @(negedge clk);
         if (k <= 4)      exp_v = {3'd0, 3'd0, 4'b0001, 4'b0000};
         else if (k <= 6) exp_v = {3'd1, 3'd0, 4'b0000, 4'b0001};
         else if (k == 7) exp_v = {3'd2, 3'd0, 4'b0000, 4'b0000};
         else             exp_v = {3'd0, 3'd1, 4'b0010, 4'b0000};
         checks++;
         if ({bus3.phase, bus3.active_way, bus3.green, bus3.yellow} !== exp_v) begin
            errors++;
            $display("[TB] FAIL demand_ignored k=%0d: got %b, want %b (ph,way,g,y)",
                     k, {bus3.phase, bus3.active_way, bus3.green, bus3.yellow}, exp_v);
         end
      end
   endtask
`endif

   initial begin
      reset0 = 1'b0;
      reset1 = 1'b0;
      reset2 = 1'b0;
      reset3 = 1'b0;
      bus0.night_mode = 1'b0;
      bus1.night_mode = 1'b0;
      bus2.night_mode = 1'b0;
      bus3.night_mode = 1'b0;
      bus0.demand = '0;
      bus1.demand = '0;
      bus2.demand = '0;
      bus3.demand = '0;
      test_reset();
      test_day_cycle();
      test_allred_zero();
      test_night_entry();
      test_night_exit();
      test_reset_mid_yellow();
      test_demand();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
